seq_alu_core: RTL and testbench
===============================

Name: seq_alu_core

Overview:
Parametrised, registered successor to the 8-bit combinational arithmetic_logic_unit. It keeps the same 4-bit operation encoding and adds a valid/ready handshake on both input and output. Add, subtract, shift, rotate, logic and compare complete in one cycle. Multiply and divide run as multi-cycle shift-add and restoring-division sequences. It sits between the operand fetch logic and the writeback logic of the datapath.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 4..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
input_a  input  WIDTH  first operand
input_b  input  WIDTH  second operand
operation_select  input  4  operation code, sampled on accept
start_valid  input  1  operands and opcode are valid
start_ready  output  1  core can accept a new operation
result_output  output  WIDTH  result; low product half or quotient
result_high  output  WIDTH  high product half or remainder; 0 for other ops
carry_flag  output  1  carry, borrow, shifted-out bit, or error
zero_flag  output  1  result_output == 0
result_valid  output  1  outputs hold a completed result
result_ready  input  1  consumer takes the result

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Values on reset: state IDLE, start_ready=1, result_valid=0, and all data outputs and flags 0.
- Reset mid-operation: any sequence in progress is aborted. No result is produced, and the core is back in IDLE on the first clk edge after reset deasserts.
- Accept: an operation is accepted on a clk edge where start_valid && start_ready. input_a, input_b and operation_select are captured at that edge. Input changes after the accept edge are ignored.
- States:
  - IDLE: start_ready=1.
  - MUL and DIV: busy; run for exactly WIDTH iterations, then go to DONE.
  - DONE: result_valid=1.
- Transitions:
  - IDLE -> DONE for single-cycle ops. Latency is 1: result_valid rises on the edge after accept.
  - IDLE -> MUL or DIV; result_valid rises WIDTH+1 edges after accept.
  - DONE -> IDLE on an edge with result_ready=1.
- start_ready is 1 only in IDLE. There is no back-to-back overlap, so the minimum issue interval is 2 cycles.
- Backpressure: while result_valid=1 and result_ready=0, all outputs hold stable.
- Opcodes, with carry_flag:
  - 0000 add: carry = carry-out.
  - 0001 sub A-B: carry = borrow (1 when A<B unsigned).
  - 0010 mul unsigned: full 2*WIDTH product in {result_high, result_output}; carry = |result_high.
  - 0011 div unsigned: quotient in result_output, remainder in result_high.
    - Divide by zero: quotient all ones, remainder = A, carry = 1, still takes WIDTH+1 cycles.
    - Otherwise carry = 0.
  - 0100 shl by 1: carry = A[WIDTH-1].
  - 0101 shr logical by 1: carry = A[0].
  - 0110 rotl by 1 / 0111 rotr by 1: carry = 0.
  - 1000 and, 1001 or, 1010 xor, 1011 nor, 1100 nand, 1101 xnor: carry = 0.
  - 1110 A>B unsigned / 1111 A==B: result_output = {0..0, cmp}; carry = 0.
- zero_flag is computed from the final result_output only. It is registered together with the result.
- Arithmetic uses unsigned WIDTH-bit operands. add and sub wrap modulo 2^WIDTH.

Optional Feature:
SEQ_ALU_DIV_EN
- Defined: opcode 0011 performs restoring division as described above.
- Undefined: DIV state and divider logic are not compiled. Opcode 0011 completes in 1 cycle with result_output=0, result_high=0, carry_flag=1 (illegal-op indication).

Test Plan:
- Add (WIDTH=8), A=0x0F, B=0xF0, op 0000 -> result 0xFF, carry 0, zero 0. result_valid exactly 1 cycle after accept.
- Sub, A=0x0F, B=0xF0, op 0001 -> result 0x1F, carry 1. Equal, A=B=0xAA, op 1111 -> result 0x01.
- Multiply:
  - A=0x03, B=0x04, op 0010 -> result 0x0C, high 0x00, carry 0. result_valid exactly 9 cycles after accept.
  - A=0xFF, B=0xFF -> result 0x01, high 0xFE, carry 1.
- Shifts and rotates, A=0xAA:
  - op 0100 -> 0x54, carry 1.
  - op 0111 -> 0x55, carry 0.
  - A=0xFF, B=0x0F, op 1101 -> 0x0F.
- Divide (with SEQ_ALU_DIV_EN):
  - A=0x64, B=0x07 -> quotient 0x0E, remainder 0x02.
  - B=0x00 -> quotient 0xFF, remainder 0x64, carry 1.
  - Without the macro, op 0011 -> 0x00, carry 1 after 1 cycle.
- Handshake and reset:
  - Hold result_ready=0 for 5 cycles -> outputs stable, start_ready=0.
  - Assert reset during MUL cycle 4 -> result_valid=0 and start_ready=1 immediately, and no stale result afterwards.

Source files
------------

// File: rtl/seq_alu_core.sv
// seq_alu_core: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops (add/sub/shift/rotate/logic/compare) finish one edge after accept.
// Multiply (shift-add) and divide (restoring) take WIDTH+1 edges.
// Configuration macro: SEQ_ALU_DIV_EN enables the divider. Without it, opcode 0011
// finishes in one cycle and flags an illegal op with carry_flag=1.
module seq_alu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [3:0]       operation_select,
  input  logic             start_valid,
  output logic             start_ready,
  output logic [WIDTH-1:0] result_output,
  output logic [WIDTH-1:0] result_high,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2, S_DIV = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_e;
`endif

  state_e state_q, state_d;

  // Iteration registers: acc_q is the running high half / partial remainder,
  // lo_q starts as operand A and ends as the low product / quotient.
  logic [WIDTH-1:0] acc_q, lo_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q, high_q;
  logic             carry_q, zero_q;

  logic             accept, is_mul, is_div;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH:0]   mul_sum;

  assign accept = (state_q == S_IDLE) && start_valid;
  assign is_mul = (operation_select == 4'h2);
`ifdef SEQ_ALU_DIV_EN
  assign is_div = (operation_select == 4'h3);
`else
  assign is_div = 1'b0;
`endif

  // State register; reset aborts any sequence in progress.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_valid) state_d = is_mul ? S_MUL : (is_div ? state_e'(2'd3) : S_DONE);
      S_MUL:  if (cnt_q == LAST) state_d = S_DONE;
`ifdef SEQ_ALU_DIV_EN
      S_DIV:  if (cnt_q == LAST) state_d = S_DONE;
`endif
      S_DONE: if (result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    start_ready  = (state_q == S_IDLE);
    result_valid = (state_q == S_DONE);
  end

  // Single-cycle result computed straight from the operands being accepted.
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sum_w    = {1'b0, input_a} + {1'b0, input_b};
    diff_w   = {1'b0, input_a} - {1'b0, input_b};
    case (operation_select)
      4'h0: begin sc_res = sum_w[WIDTH-1:0];  sc_carry = sum_w[WIDTH];  end
      4'h1: begin sc_res = diff_w[WIDTH-1:0]; sc_carry = diff_w[WIDTH]; end
`ifndef SEQ_ALU_DIV_EN
      4'h3: begin sc_res = '0; sc_carry = 1'b1; end
`endif
      4'h4: begin sc_res = {input_a[WIDTH-2:0], 1'b0}; sc_carry = input_a[WIDTH-1]; end
      4'h5: begin sc_res = {1'b0, input_a[WIDTH-1:1]}; sc_carry = input_a[0]; end
      4'h6: sc_res = {input_a[WIDTH-2:0], input_a[WIDTH-1]};
      4'h7: sc_res = {input_a[0], input_a[WIDTH-1:1]};
      4'h8: sc_res = input_a & input_b;
      4'h9: sc_res = input_a | input_b;
      4'hA: sc_res = input_a ^ input_b;
      4'hB: sc_res = ~(input_a | input_b);
      4'hC: sc_res = ~(input_a & input_b);
      4'hD: sc_res = ~(input_a ^ input_b);
      4'hE: sc_res = {{(WIDTH-1){1'b0}}, (input_a > input_b)};
      4'hF: sc_res = {{(WIDTH-1){1'b0}}, (input_a == input_b)};
      default: ;
    endcase
  end

  // One shift-add step: add B when the multiplier LSB is set, then shift the pair right.
  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  // One restoring step: shift in the next dividend bit, subtract B if it fits.
  // Divide by zero falls out naturally: every step "fits", giving all-ones and remainder A.
  assign div_shift = {acc_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_rem   = div_shift[WIDTH-1:0] - b_q;
`endif

  // Datapath: capture operands on accept, iterate, and register final results with flags.
  // NOTE: all datapath registers are reset so outputs read zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      high_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          acc_q <= '0;
          lo_q  <= input_a;
          b_q   <= input_b;
          cnt_q <= '0;
          if (!is_mul && !is_div) begin
            res_q   <= sc_res;
            high_q  <= '0;
            carry_q <= sc_carry;
            zero_q  <= (sc_res == '0);
          end
        end
        S_MUL: begin
          if (cnt_q == LAST) begin
            res_q   <= lo_q;
            high_q  <= acc_q;
            carry_q <= |acc_q;
            zero_q  <= (lo_q == '0);
          end else begin
            acc_q <= mul_sum[WIDTH:1];
            lo_q  <= {mul_sum[0], lo_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef SEQ_ALU_DIV_EN
        S_DIV: begin
          if (cnt_q == LAST) begin
            res_q   <= lo_q;
            high_q  <= acc_q;
            carry_q <= (b_q == '0);
            zero_q  <= (lo_q == '0);
          end else begin
            acc_q <= div_ge ? div_rem : div_shift[WIDTH-1:0];
            lo_q  <= {lo_q[WIDTH-2:0], div_ge};
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign result_output = res_q;
  assign result_high   = high_q;
  assign carry_flag    = carry_q;
  assign zero_flag     = zero_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Testbench for seq_alu_core (WIDTH=8), randomized stimulus against an arithmetic model.
// Honours SEQ_ALU_DIV_EN when it is defined for the build.
module tb_seq_alu_core;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] input_a, input_b;
  logic [3:0]   operation_select;
  logic         start_valid, start_ready;
  logic [W-1:0] result_output, result_high;
  logic         carry_flag, zero_flag, result_valid, result_ready;

  int checks = 0;
  int errors = 0;

  seq_alu_core #(.WIDTH(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .input_a          (input_a),
    .input_b          (input_b),
    .operation_select (operation_select),
    .start_valid      (start_valid),
    .start_ready      (start_ready),
    .result_output    (result_output),
    .result_high      (result_high),
    .carry_flag       (carry_flag),
    .zero_flag        (zero_flag),
    .result_valid     (result_valid),
    .result_ready     (result_ready)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic from the opcode table.
  function automatic void model(input logic [3:0] op, input int a, input int b,
                                output int r, output int h, output bit c, output int lat);
    r = 0; h = 0; c = 1'b0; lat = 1;
    case (op)
      4'h0: begin r = (a + b) % MOD; c = (a + b) >= MOD; end
      4'h1: begin r = (a - b + MOD) % MOD; c = a < b; end
      4'h2: begin r = (a * b) % MOD; h = (a * b) / MOD; c = h != 0; lat = W + 1; end
      4'h3: begin
`ifdef SEQ_ALU_DIV_EN
        lat = W + 1;
        if (b == 0) begin r = MOD - 1; h = a; c = 1'b1; end
        else        begin r = a / b;   h = a % b; end
`else
        c = 1'b1;
`endif
      end
      4'h4: begin r = (a * 2) % MOD; c = a >= MOD / 2; end
      4'h5: begin r = a / 2; c = (a % 2) == 1; end
      4'h6: r = (a * 2) % MOD + a / (MOD / 2);
      4'h7: r = a / 2 + (a % 2) * (MOD / 2);
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = (MOD - 1) - (a | b);
      4'hC: r = (MOD - 1) - (a & b);
      4'hD: r = (MOD - 1) - (a ^ b);
      4'hE: r = (a > b) ? 1 : 0;
      4'hF: r = (a == b) ? 1 : 0;
      default: ;
    endcase
  endfunction

  // Issue one operation, wait (bounded) for result_valid, return observed outputs.
  // lat = -1 signals that no result arrived in time. Inputs are scrambled after accept.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                       input bit consume, output int r, output int h, output bit c,
                       output bit z, output int lat);
    @(negedge clk);
    input_a = a; input_b = b; operation_select = op; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    input_a = ~a; input_b = ~b; operation_select = ~op;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin lat = i; break; end
    end
    r = int'(result_output); h = int'(result_high); c = carry_flag; z = zero_flag;
    if (consume && lat > 0) begin
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
    input_a = '0; input_b = '0; operation_select = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (start_ready !== 1'b1)   begin errors++; $display("FAIL reset_start_ready got %b want 1", start_ready); end
    if (result_valid !== 1'b0)  begin errors++; $display("FAIL reset_result_valid got %b want 0", result_valid); end
    if (result_output !== '0)   begin errors++; $display("FAIL reset_result got %h want 00", result_output); end
    if (result_high !== '0)     begin errors++; $display("FAIL reset_high got %h want 00", result_high); end
    if (carry_flag !== 1'b0)    begin errors++; $display("FAIL reset_carry got %b want 0", carry_flag); end
    if (zero_flag !== 1'b0)     begin errors++; $display("FAIL reset_zero got %b want 0", zero_flag); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic [3:0]   op;
    int           er, eh;
    bit           ec;
    int           elat;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    int r, h, lat;
    bit c, z;
    v.push_back('{8'h0F, 8'hF0, 4'h0, 'hFF, 0, 1'b0, 1});
    v.push_back('{8'h0F, 8'hF0, 4'h1, 'h1F, 0, 1'b1, 1});
    v.push_back('{8'hAA, 8'hAA, 4'hF, 'h01, 0, 1'b0, 1});
    v.push_back('{8'h03, 8'h04, 4'h2, 'h0C, 0, 1'b0, 9});
    v.push_back('{8'hFF, 8'hFF, 4'h2, 'h01, 'hFE, 1'b1, 9});
    v.push_back('{8'hAA, 8'h00, 4'h4, 'h54, 0, 1'b1, 1});
    v.push_back('{8'hAA, 8'h00, 4'h7, 'h55, 0, 1'b0, 1});
    v.push_back('{8'hFF, 8'h0F, 4'hD, 'h0F, 0, 1'b0, 1});
    v.push_back('{8'hF0, 8'h10, 4'h0, 'h00, 0, 1'b1, 1});
`ifdef SEQ_ALU_DIV_EN
    v.push_back('{8'h64, 8'h07, 4'h3, 'h0E, 'h02, 1'b0, 9});
    v.push_back('{8'h64, 8'h00, 4'h3, 'hFF, 'h64, 1'b1, 9});
`else
    v.push_back('{8'h64, 8'h07, 4'h3, 'h00, 0, 1'b1, 1});
`endif
    foreach (v[i]) begin
      do_op(v[i].a, v[i].b, v[i].op, 1'b1, r, h, c, z, lat);
      checks += 5;
      if (r !== v[i].er)     begin errors++; $display("FAIL dir%0d_result op=%h got %h want %h", i, v[i].op, r, v[i].er); end
      if (h !== v[i].eh)     begin errors++; $display("FAIL dir%0d_high op=%h got %h want %h", i, v[i].op, h, v[i].eh); end
      if (c !== v[i].ec)     begin errors++; $display("FAIL dir%0d_carry op=%h got %b want %b", i, v[i].op, c, v[i].ec); end
      if (z !== (v[i].er == 0)) begin errors++; $display("FAIL dir%0d_zero op=%h got %b want %b", i, v[i].op, z, v[i].er == 0); end
      if (lat !== v[i].elat) begin errors++; $display("FAIL dir%0d_latency op=%h got %0d want %0d", i, v[i].op, lat, v[i].elat); end
    end
  endtask

  task automatic test_random();
    int r, h, lat, er, eh, elat;
    bit c, z, ec;
    logic [W-1:0] a, b;
    logic [3:0] op;
    for (int n = 0; n < 150; n++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      op = 4'($urandom_range(0, 15));
      if (n % 10 == 3) b = '0;
      if (n % 10 == 7) a = b;
      model(op, int'(a), int'(b), er, eh, ec, elat);
      do_op(a, b, op, 1'b1, r, h, c, z, lat);
      checks += 5;
      if (r !== er)        begin errors++; $display("FAIL rnd_result op=%h a=%h b=%h got %h want %h", op, a, b, r, er); end
      if (h !== eh)        begin errors++; $display("FAIL rnd_high op=%h a=%h b=%h got %h want %h", op, a, b, h, eh); end
      if (c !== ec)        begin errors++; $display("FAIL rnd_carry op=%h a=%h b=%h got %b want %b", op, a, b, c, ec); end
      if (z !== (er == 0)) begin errors++; $display("FAIL rnd_zero op=%h a=%h b=%h got %b want %b", op, a, b, z, er == 0); end
      if (lat !== elat)    begin errors++; $display("FAIL rnd_latency op=%h got %0d want %0d", op, lat, elat); end
    end
  endtask

  task automatic test_backpressure();
    int r, h, lat, er, eh, elat;
    bit c, z, ec;
    logic [W-1:0] a, b;
    a = W'($urandom_range(16, 255));
    b = W'($urandom_range(16, 255));
    model(4'h2, int'(a), int'(b), er, eh, ec, elat);
    do_op(a, b, 4'h2, 1'b0, r, h, c, z, lat);
    checks += 3;
    if (r !== er)     begin errors++; $display("FAIL bp_result got %h want %h", r, er); end
    if (h !== eh)     begin errors++; $display("FAIL bp_high got %h want %h", h, eh); end
    if (lat !== elat) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, elat); end
    // Offer a competing operation while the result is stalled; it must not be taken.
    input_a = 8'h01; input_b = 8'h01; operation_select = 4'h0; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks += 3;
      if (result_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d got %b want 1", i, result_valid); end
      if (start_ready !== 1'b0)  begin errors++; $display("FAIL bp_start_ready cyc%0d got %b want 0", i, start_ready); end
      if (int'(result_output) !== er || int'(result_high) !== eh || carry_flag !== ec || zero_flag !== (er == 0))
        begin errors++; $display("FAIL bp_stable cyc%0d got %h/%h/%b want %h/%h/%b", i, result_output, result_high, carry_flag, er, eh, ec); end
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    checks += 2;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", result_valid); end
    if (start_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_ready got %b want 1", start_ready); end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int er, eh, elat, got;
    bit ec;
    bit sr;
    got = 0;
    result_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      input_a = W'($urandom);
      input_b = W'($urandom);
      operation_select = 4'($urandom_range(4, 15));
      if (i % 3 == 0) operation_select = 4'($urandom_range(0, 1));
      start_valid = 1'b1;
      sr = start_ready;
      if (sr) begin
        model(operation_select, int'(input_a), int'(input_b), er, eh, ec, elat);
        exp_q.push_back(er + (int'(ec) << W));
      end
      @(posedge clk);
      #1;
      if (result_valid) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got %h want none", result_output);
        end else begin
          er = exp_q.pop_front();
          if ((int'(result_output) + (int'(carry_flag) << W)) !== er)
            begin errors++; $display("FAIL b2b_result got %h/%b want %h", result_output, carry_flag, er); end
        end
      end
    end
    start_valid = 1'b0;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    checks++;
    if (got !== 10) begin errors++; $display("FAIL b2b_throughput got %0d results want 10", got); end
  endtask

  task automatic test_reset_mid();
    int r, h, lat, er, eh, elat;
    bit c, z, ec;
    bit stale;
    @(negedge clk);
    input_a = 8'hFF; input_b = 8'hFF; operation_select = 4'h2; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks += 3;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", result_valid); end
    if (start_ready !== 1'b1)  begin errors++; $display("FAIL midrst_ready got %b want 1", start_ready); end
    if (result_output !== '0 || result_high !== '0)
      begin errors++; $display("FAIL midrst_data got %h/%h want 00/00", result_output, result_high); end
    @(negedge clk);
    reset = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (result_valid !== 1'b0 || start_ready !== 1'b1) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin errors++; $display("FAIL midrst_stale got 1 want 0"); end
    model(4'h1, 'h30, 'h10, er, eh, ec, elat);
    do_op(8'h30, 8'h10, 4'h1, 1'b1, r, h, c, z, lat);
    checks += 2;
    if (r !== er)     begin errors++; $display("FAIL midrst_after_result got %h want %h", r, er); end
    if (lat !== elat) begin errors++; $display("FAIL midrst_after_latency got %0d want %0d", lat, elat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
